// File: rtl/fifo_top_sync.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Status outputs (full, empty, count modulo DEPTH) come straight from registered state.
module fifo_top_sync #(
    parameter int  DEPTH  = 4,
    parameter type data_t = logic [36:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$bits(data_t)-1:0] data_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    output logic [$bits(data_t)-1:0] data_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic                     isFull_o,
    output logic                     isEmpty_o,
    output logic [$clog2(DEPTH)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    data_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     occ;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);

    // Handshakes depend only on registered occupancy, never on the opposite side's inputs.
    assign push = data_valid_i && !full;
    assign pop  = data_ready_i && !empty;

    assign data_ready_o = !full;
    assign data_valid_o = !empty;
    assign isFull_o     = full;
    assign isEmpty_o    = empty;
    assign count_o      = occ[AW-1:0];
    assign data_o       = mem[rd_ptr];

    // Storage is never cleared; a write is suppressed on a reset edge.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem[wr_ptr] <= data_t'(data_i);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (AW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_top_sync.sv
// Bench for fifo_top_sync: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_fifo_top_sync;

    localparam int DEPTH = 4;
    localparam int W     = 37;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [W-1:0]  data_i;
    logic          data_valid_i;
    logic          data_ready_o;
    logic [W-1:0]  data_o;
    logic          data_valid_o;
    logic          data_ready_i;
    logic          isFull_o;
    logic          isEmpty_o;
    logic [1:0]    count_o;

    fifo_top_sync #(
        .DEPTH  (DEPTH),
        .data_t (logic [36:0])
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .isFull_o     (isFull_o),
        .isEmpty_o    (isEmpty_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model: a plain queue of accepted words.
    logic [W-1:0] model_q[$];
    bit           model_on = 1'b0;

    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (rst_i) begin
            model_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            do_push = data_valid_i && (model_q.size() < DEPTH);
            do_pop  = data_ready_i && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(data_i);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_empty", 64'(isEmpty_o),    64'(model_q.size() == 0));
            chk("m_full",  64'(isFull_o),     64'(model_q.size() == DEPTH));
            chk("m_count", 64'(count_o),      64'(model_q.size() % DEPTH));
            chk("m_valid", 64'(data_valid_o), 64'(model_q.size() != 0));
            chk("m_ready", 64'(data_ready_o), 64'(model_q.size() != DEPTH));
            if (model_q.size() != 0) begin
                chk("m_data", 64'(data_o), 64'(model_q[0]));
            end
        end
    end

    // Offer one word for up to 10 cycles; acc reports whether it was taken.
    task automatic push_word(input logic [W-1:0] w, output bit acc);
        acc = 1'b0;
        data_i = w;
        data_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (data_ready_o) acc = 1'b1;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        data_valid_i = 1'b0;
    endtask

    // Request one word for up to 10 cycles; got reports whether one was popped.
    task automatic pop_word(output logic [W-1:0] d, output bit got);
        got = 1'b0;
        d = '0;
        data_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (data_valid_o) begin
                got = 1'b1;
                d = data_o;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        data_ready_i = 1'b0;
    endtask

    logic [W-1:0] words [7];
    logic [W-1:0] cw    [3];
    logic [W-1:0] d, v, a, b, y;
    bit           ok;
    int           exp_fill [4] = '{1, 2, 3, 0};
    int           exp_drain[4] = '{3, 2, 1, 0};

    initial begin
        rst_i = 1'b1;
        data_i = '0;
        data_valid_i = 1'b0;
        data_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) words[i] = W'({$urandom, $urandom});

        repeat (5) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_empty", 64'(isEmpty_o), 64'd1);
        chk("rst_full",  64'(isFull_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(data_valid_o), 64'd0);
        chk("rst_ready", 64'(data_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Fill with the consumer stalled; words 5..7 must be refused.
        for (int i = 0; i < 7; i++) begin
            push_word(words[i], ok);
            chk("fill_acc", 64'(ok), 64'(i < 4));
            if (i < 4) begin
                chk("fill_count", 64'(count_o), 64'(exp_fill[i]));
                chk("fill_full",  64'(isFull_o), 64'(i == 3));
            end else begin
                chk("stall_ready", 64'(data_ready_o), 64'd0);
            end
        end

        // Drain; the fifth request must time out.
        for (int i = 0; i < 5; i++) begin
            pop_word(d, ok);
            if (i < 4) begin
                chk("drain_got",   64'(ok), 64'd1);
                chk("drain_data",  64'(d), 64'(words[i]));
                chk("drain_count", 64'(count_o), 64'(exp_drain[i]));
            end else begin
                chk("drain_timeout", 64'(ok), 64'd0);
            end
        end
        chk("drain_empty", 64'(isEmpty_o), 64'd1);

        // Single-entry round trips across two pointer wraps.
        for (int i = 0; i < 8; i++) begin
            v = W'({$urandom, $urandom});
            push_word(v, ok);
            chk("rt_acc", 64'(ok), 64'd1);
            repeat (2) @(posedge clk);
            #1;
            pop_word(d, ok);
            chk("rt_got",  64'(ok), 64'd1);
            chk("rt_data", 64'(d), 64'(v));
        end

        // Occupancy 2 with simultaneous push and pop for 3 cycles.
        a = W'({$urandom, $urandom});
        b = W'({$urandom, $urandom});
        for (int i = 0; i < 3; i++) cw[i] = W'({$urandom, $urandom});
        push_word(a, ok);
        push_word(b, ok);
        data_valid_i = 1'b1;
        data_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = cw[i];
            @(negedge clk);
            chk("both_count", 64'(count_o), 64'd2);
            chk("both_data",  64'(data_o), (i == 0) ? 64'(a) : (i == 1) ? 64'(b) : 64'(cw[0]));
            @(posedge clk);
            #1;
        end
        data_valid_i = 1'b0;
        data_ready_i = 1'b0;
        chk("both_count_after", 64'(count_o), 64'd2);
        pop_word(d, ok);
        chk("both_tail0", 64'(d), 64'(cw[1]));
        pop_word(d, ok);
        chk("both_tail1", 64'(d), 64'(cw[2]));

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) push_word(words[i] ^ W'(i + 1), ok);
        chk("pre_rst_count", 64'(count_o), 64'd3);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        chk("mid_rst_empty", 64'(isEmpty_o), 64'd1);
        chk("mid_rst_count", 64'(count_o), 64'd0);
        chk("mid_rst_valid", 64'(data_valid_o), 64'd0);
        pop_word(d, ok);
        chk("mid_rst_no_old", 64'(ok), 64'd0);
        y = W'({$urandom, $urandom});
        push_word(y, ok);
        pop_word(d, ok);
        chk("post_rst_data", 64'(d), 64'(y));

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
